// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard bundle.
// master: the ID stage / pipeline controller (drives decode info, reads hazards).
// slave : the hazard_scoreboard itself.
// FWD_W follows the scoreboard depth so the select and counter widths
// always agree with the instance sharing the same STAGES value.
interface hazard_scoreboard_if #(
  parameter int STAGES     = 3,
  parameter int REG_ADDR_W = 5
);
  localparam int FWD_W = $clog2(STAGES + 1);

  logic                  en;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_is_load;
  logic                  flush;

  logic                  stall;
  logic [FWD_W-1:0]      fwd_sel_1;
  logic [FWD_W-1:0]      fwd_sel_2;
  logic [FWD_W-1:0]      inflight_cnt;

  modport master (
    output en, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_is_load, flush,
    input  stall, fwd_sel_1, fwd_sel_2, inflight_cnt
  );

  modport slave (
    input  en, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_is_load, flush,
    output stall, fwd_sel_1, fwd_sel_2, inflight_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard for the in-order core.
// Tracks {valid, rd, load} of every instruction issued from ID through
// STAGES downstream entries (entry 0 = EXE) and flags RAW hazards against
// the operands currently in ID.
// Build option: define HAZARD_FWD_EN to enable forwarding selects and the
// load-latency-only stall; without it every RAW hit stalls until retire
// and the forwarding selects are tied to zero.

// Per-entry comparator: does this scoreboard entry produce either ID operand?
module hazard_sb_lane #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  vld_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  rs1_used_i,
  input  logic                  rs2_used_i,
  output logic                  hit1_o,
  output logic                  hit2_o
);
  // x0 is hardwired zero, so a read of it never depends on anything in flight.
  assign hit1_o = vld_i & id_valid_i & rs1_used_i & (rs1_i != '0) & (rd_i == rs1_i);
  assign hit2_o = vld_i & id_valid_i & rs2_used_i & (rs2_i != '0) & (rd_i == rs2_i);
endmodule

module hazard_scoreboard #(
  parameter int  STAGES     = 3,
  parameter int  REG_ADDR_W = 5,
  parameter int  LOAD_LAT   = 1,
  localparam int FWD_W      = $clog2(STAGES + 1)
) (
  input  logic          clk_i,
  input  logic          arst_i,
  hazard_scoreboard_if.slave hz
);

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  ld;
  } entry_t;

  entry_t [STAGES-1:0] ent_q, ent_d;
  logic   [FWD_W-1:0]  cnt_q, cnt_d;

  logic [STAGES-1:0] hit1, hit2;
  logic              stall_w;
  logic              issue;
  logic              retire;

  // The oldest entry's load flag has no consumer: it is past every
  // load-latency window and is about to retire.
  logic unused_ld;
  assign unused_ld = ent_q[STAGES-1].ld;

  // One comparator lane per tracked stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_lane
    hazard_sb_lane #(.REG_ADDR_W(REG_ADDR_W)) u_lane (
      .vld_i      (ent_q[k].v),
      .rd_i       (ent_q[k].rd),
      .id_valid_i (hz.id_valid),
      .rs1_i      (hz.id_rs1),
      .rs2_i      (hz.id_rs2),
      .rs1_used_i (hz.id_rs1_used),
      .rs2_used_i (hz.id_rs2_used),
      .hit1_o     (hit1[k]),
      .hit2_o     (hit2[k])
    );
  end

`ifdef HAZARD_FWD_EN
  // Loads whose data is still in flight in the first LOAD_LAT entries
  // cannot be forwarded yet.
  logic [STAGES-1:0] ld_blk;
  for (genvar k = 0; k < STAGES; k++) begin : g_ldblk
    if (k < LOAD_LAT) begin : g_early
      assign ld_blk[k] = ent_q[k].ld;
    end else begin : g_late
      assign ld_blk[k] = 1'b0;
    end
  end

  logic [FWD_W-1:0] sel1, sel2;
  logic             blk1, blk2;

  // Priority chain: walk oldest to youngest so the youngest hit lands last.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    blk1 = 1'b0;
    blk2 = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (hit1[k]) begin
        sel1 = FWD_W'(k + 1);
        blk1 = ld_blk[k];
      end
      if (hit2[k]) begin
        sel2 = FWD_W'(k + 1);
        blk2 = ld_blk[k];
      end
    end
  end

  assign stall_w      = blk1 | blk2;
  assign hz.fwd_sel_1 = sel1;
  assign hz.fwd_sel_2 = sel2;
`else
  // No bypass network: any pending producer holds ID until it retires.
  assign stall_w      = (|hit1) | (|hit2);
  assign hz.fwd_sel_1 = '0;
  assign hz.fwd_sel_2 = '0;
`endif

  assign hz.stall        = stall_w;
  assign hz.inflight_cnt = cnt_q;

  // Flush wins over stall: a squashed instruction never enters EXE, and
  // writes to x0 are never tracked.
  assign issue  = hz.id_valid & hz.id_reg_write & (hz.id_rd != '0) & ~stall_w & ~hz.flush;
  assign retire = ent_q[STAGES-1].v;

  // Next-state: shift the scoreboard and keep the counter in step with it.
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (hz.en) begin
      ent_d[0] = issue ? entry_t'({1'b1, hz.id_rd, hz.id_is_load}) : entry_t'('0);
      for (int k = 1; k < STAGES; k++) begin
        ent_d[k] = ent_q[k-1];
      end
      unique case ({issue, retire})
        2'b10:   cnt_d = cnt_q + FWD_W'(1);
        2'b01:   cnt_d = cnt_q - FWD_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers; reset drops in-flight entries without retire accounting.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (STAGES=3, LOAD_LAT=1).
// Expected values follow the HAZARD_FWD_EN build setting.
module tb_hazard_scoreboard;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic arst;
  int   total = 0;
  int   bad   = 0;

  hazard_scoreboard_if #(.STAGES(3), .REG_ADDR_W(5)) hz ();

  hazard_scoreboard #(.STAGES(3), .REG_ADDR_W(5), .LOAD_LAT(1)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .hz     (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chko(input string tag, input logic [31:0] st, input logic [31:0] s1,
                      input logic [31:0] s2);
    chk({tag, ".stall"}, 32'(hz.stall), st);
    chk({tag, ".sel1"},  32'(hz.fwd_sel_1), s1);
    chk({tag, ".sel2"},  32'(hz.fwd_sel_2), s2);
  endtask

  task automatic chkc(input string tag, input logic [31:0] c);
    chk({tag, ".cnt"}, 32'(hz.inflight_cnt), c);
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic ld, input logic fl);
    hz.id_valid     = v;
    hz.id_rs1       = rs1;
    hz.id_rs1_used  = u1;
    hz.id_rs2       = rs2;
    hz.id_rs2_used  = u2;
    hz.id_rd        = rd;
    hz.id_reg_write = rw;
    hz.id_is_load   = ld;
    hz.flush        = fl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst  = 1'b1;
    hz.en = 1'b1;
    idle();
    #12;
    chko("rst", 0, 0, 0);
    chkc("rst", 0);
    arst = 1'b0;
    tick();

    // ALU producer rd=5, consumer reads rs1=5 for four cycles.
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0); #1;
    chk("alu.issue.stall", 32'(hz.stall), 0);
    tick();
    chkc("alu.issued", 1);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0); #1;
    chko("alu.d1", FWD ? 0 : 1, FWD ? 1 : 0, 0);
    tick();
    chko("alu.d2", FWD ? 0 : 1, FWD ? 2 : 0, 0);
    tick();
    chko("alu.d3", FWD ? 0 : 1, FWD ? 3 : 0, 0);
    chkc("alu.d3", 1);
    tick();
    chko("alu.d4", 0, 0, 0);
    chkc("alu.d4", 0);

    // Load rd=7 followed by a consumer of rs2=7 that itself writes rd=9.
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drv(1, 0, 0, 7, 1, 9, 1, 0, 0); #1;
`ifdef HAZARD_FWD_EN
    chko("ld.a", 1, 0, 1);
    chkc("ld.a", 1);
    tick();
    chko("ld.b", 0, 0, 2);
    chkc("ld.b", 1);
    tick();
    chkc("ld.c", 2);
`else
    chko("ld.a", 1, 0, 0);
    chkc("ld.a", 1);
    tick();
    chko("ld.b", 1, 0, 0);
    tick();
    chko("ld.c", 1, 0, 0);
    tick();
    chko("ld.d", 0, 0, 0);
    chkc("ld.d", 0);
    tick();
    chkc("ld.e", 1);
`endif
    idle();
    tick(); tick(); tick();
    chkc("ld.drain", 0);

    // Priority: rd=3 in e[0] and e[2], rd=4 in e[1].
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0); tick();
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
    chkc("pri.fill", 3);
    drv(1, 3, 1, 3, 1, 0, 0, 0, 0); #1;
    chko("pri", FWD ? 0 : 1, FWD ? 1 : 0, FWD ? 1 : 0);
    drv(1, 0, 1, 0, 1, 0, 1, 0, 0); #1;
    chko("pri.x0", 0, 0, 0);
    tick();
    chkc("pri.x0", 2);
    drv(1, 4, 1, 3, 1, 0, 0, 0, 0); #1;
    chko("pri2", FWD ? 0 : 1, FWD ? 3 : 0, FWD ? 2 : 0);
    idle();
    tick(); tick(); tick();
    chkc("pri.drain", 0);
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    chkc("x0.noissue", 0);

    // Flush over a load-use stall, then freeze with en=0.
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    chkc("fl.load", 1);
    drv(1, 7, 1, 0, 0, 8, 1, 0, 1); #1;
    chko("fl", 1, FWD ? 1 : 0, 0);
    tick();
    drv(1, 8, 1, 0, 0, 0, 0, 0, 0); #1;
    chko("fl.noiss", 0, 0, 0);
    chkc("fl.noiss", 1);
    hz.en = 1'b0;
    drv(1, 7, 1, 0, 0, 0, 0, 0, 0); #1;
    chko("frz0", FWD ? 0 : 1, FWD ? 2 : 0, 0);
    tick(); tick(); tick(); tick();
    chko("frz4", FWD ? 0 : 1, FWD ? 2 : 0, 0);
    chkc("frz4", 1);
    drv(1, 9, 1, 0, 0, 0, 0, 0, 0); #1;
    chko("frz.track", 0, 0, 0);
    hz.en = 1'b1;
    drv(1, 7, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chko("thaw", FWD ? 0 : 1, FWD ? 3 : 0, 0);
    tick();
    chkc("thaw.retire", 0);

    // Back-to-back issue: counter saturates at the scoreboard depth.
    for (int i = 0; i < 10; i++) begin
      drv(1, 0, 0, 0, 0, 5'(i + 1), 1, 0, 0);
      tick();
      chkc($sformatf("ctr%0d", i), (i < 2) ? i + 1 : 3);
    end

    // Mid-stream reset with e[0..2] = rd 10, 9, 8.
    drv(1, 8, 1, 0, 0, 0, 0, 0, 0); #1;
    chko("prerst", FWD ? 0 : 1, FWD ? 3 : 0, 0);
    arst = 1'b1; #1;
    chko("rst.mid", 0, 0, 0);
    chkc("rst.mid", 0);
    #1 arst = 1'b0; #1;
    chko("rst.post", 0, 0, 0);
    tick();
    chko("rst.post2", 0, 0, 0);
    chkc("rst.post2", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline hazard tracker for the in-order RISC-V core. It records the destination register, write-enable and load flag of every instruction issued from ID into a shift-register scoreboard of STAGES entries (EXE, MEM, WB, …). It detects read-after-write hazards against the operands being decoded in ID. Each cycle it drives a load-use stall plus per-operand forwarding selects to the ID/EXE datapath, generalising the hazard-free fixed 5-stage pipeline to any depth and load latency.

## Interface
- STAGES, 3: number of tracked stages after ID (entry 0 = EXE, STAGES-1 = last write-back stage); legal 2..8.
- REG_ADDR_W, 5: register address width.
- LOAD_LAT, 1: number of leading entries (index < LOAD_LAT) in which load data is not yet forwardable; legal 0..STAGES-1.
- FWD_W, derived $clog2(STAGES+1): width of forward selects; not overridden.
- clk  in  1  clock; all state updates on rising edge.
- arst  in  1  reset, asynchronous, active-high.
- en  in  1  global advance enable; 0 freezes all state.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_ADDR_W  source register addresses.
- id_rs1_used, id_rs2_used  in  1  operand actually read.
- id_rd  in  REG_ADDR_W  destination register.
- id_reg_write  in  1  ID instruction writes id_rd.
- id_is_load  in  1  ID instruction is a load.
- flush  in  1  squash the ID instruction (taken branch/jump).
- stall  out  1  hold PC and IF/ID, insert bubble into EXE.
- fwd_sel_1, fwd_sel_2  out  FWD_W  0 = register file, k = result of entry k-1.
- inflight_cnt  out  FWD_W  number of valid scoreboard entries.

## Operation
- Entry e[k] = {v, rd, ld}. Issue candidate = id_valid & id_reg_write & (id_rd != 0) & !stall & !flush.
- When en=1, on each edge: e[k] <= e[k-1] for k ≥ 1 (the last entry retires); e[0] <= {1, id_rd, id_is_load} if candidate, else bubble (v=0).
- Match for operand n at k: e[k].v & (e[k].rd == id_rsn) & id_rsn_used & id_valid & (id_rsn != 0).
- The youngest (lowest k) match wins; older matches are ignored.
- With forwarding: fwd_sel_n = k+1 for the winning match, else 0.
- With forwarding: stall = 1 if either winning match has e[k].ld & k < LOAD_LAT.
- flush has priority over stall for issue. stall is still reported combinationally; the pipeline controller ignores it when flushing.
- Register x0 is never tracked and never forwarded.
- inflight_cnt is a registered counter, not a popcount. It is +1 on issue only, −1 on retire of a valid last entry only, and unchanged on both or neither. It must always equal the number of valid entries.
- When en=0: entries and counter hold; stall and fwd_sel still track the ID inputs.
- While arst is high: all entries are cleared and inflight_cnt = 0. A reset mid-stream discards in-flight entries without retire accounting.

## Timing
- Reset values: stall=0, fwd_sel_1=fwd_sel_2=0, inflight_cnt=0.
- stall and fwd_sel are combinational from the entries and ID inputs, with zero cycle latency. Path depth is STAGES comparators plus a priority chain.
- Scoreboard latency: an instruction issued at edge t appears in e[0] after t and retires at edge t+STAGES.
- A load-use pair at distance 1 with LOAD_LAT=1 stalls exactly 1 cycle. In general, distance d stalls max(0, LOAD_LAT−d+1) cycles.

## Configuration
- HAZARD_FWD_EN defined: forwarding is enabled as described above.
- HAZARD_FWD_EN undefined: fwd_sel_1 and fwd_sel_2 are tied to 0. stall = 1 whenever any match exists at any k, load or not, until that entry retires. Scoreboard and counter behaviour are unchanged.

## Test plan
- Reset: assert arst mid-stream with 3 valid entries. Required: outputs 0 immediately; inflight_cnt=0 and all entries invalid after release.
- ALU RAW: issue rd=5 non-load, then rs1=5 used on the next cycle. Required: stall=0, fwd_sel_1=1. Repeat one cycle later: fwd_sel_1=2. Without HAZARD_FWD_EN: stall=1 for 3 cycles.
- Load-use: LOAD_LAT=1, issue load rd=7, then rs2=7 used. Required: stall=1 for one cycle, a bubble enters e[0], then stall=0 and fwd_sel_2=2.
- Priority: writes to rd=3 in e[0] and e[2], rs1=rs2=3. Required: fwd_sel_1=fwd_sel_2=1. A write to rd=0 never sets a select, and inflight_cnt is unchanged.
- Flush plus stall: load-use condition with flush=1. Required: no issue and a bubble in e[0]. With en=0 held for 4 cycles, entries and inflight_cnt are frozen.
- Counter: issue on every cycle for 10 cycles with STAGES=3. Required: inflight_cnt goes 1, 2, 3 and then stays at 3 (simultaneous issue and retire).
